sensor_input_hub: RTL and testbench

Multi-channel input front end between the board sensors (accelerometer axes, push buttons) and the processor/VGA datapath. Per channel it decimates and moving-average filters raw accelerometer samples, synchronises and debounces buttons, and latches button presses. Results go out two ways: directly as flattened sign-extended words for the VGA controller, and through a registered read port that the CPU uses as a memory-mapped input.

---
 rtl/sensor_input_hub_if.sv | 10 +
 rtl/sensor_input_hub.sv | 163 ++++++++++++++++
 tb/tb_sensor_input_hub.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sensor_input_hub_if.sv
// CPU-side memory-mapped read port of the sensor input hub.
// The hub is the slave; the processor (or a bench) drives it as master.
interface sensor_input_hub_if;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/sensor_input_hub.sv
// Sensor front end: decimated moving-average accelerometer channels, debounced
// buttons with sticky press flags, and a registered CPU read port.
module sensor_input_hub #(
    parameter int NUM_AXES        = 2,
    parameter int RAW_WIDTH       = 9,
    parameter int AVG_LOG2        = 2,
    parameter int SAMPLE_DIV      = 50000,
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic [NUM_AXES*RAW_WIDTH-1:0] axis_raw_i,
    input  logic [NUM_BUTTONS-1:0]        btn_raw_i,
    output logic [NUM_AXES*32-1:0]        axis_out_o,
    output logic [NUM_BUTTONS-1:0]        btn_level_o,
    output logic                          sample_tick_o,
    sensor_input_hub_if.slave             rd_bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = RAW_WIDTH + AVG_LOG2;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   tick_q, tick_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] btn_level_q, btn_level_d;
    logic [NUM_BUTTONS-1:0] flags_q, flags_d, clear_mask;
    logic [31:0]            rd_data_q, rd_data_d;
    logic [31:0]            axis_word [NUM_AXES];

    // The tick is registered so it stays low in reset even when SAMPLE_DIV is 1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        tick_d    = (div_cnt_d == DIV_LAST);
        wptr_d    = wptr_q;
        if (tick_q) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            logic signed [RAW_WIDTH-1:0] hist_q [DEPTH];
            logic signed [RAW_WIDTH-1:0] sample, oldest;
            logic signed [SUM_W-1:0]     sample_x, oldest_x, sum_q, sum_d, avg;
            logic signed [31:0]          avg_x, axis_q;

            assign sample   = axis_raw_i[gi*RAW_WIDTH +: RAW_WIDTH];
            assign oldest   = hist_q[wptr_q];
            assign sample_x = sample;
            assign oldest_x = oldest;
            assign sum_d    = sum_q - oldest_x + sample_x;
            // Arithmetic shift floors toward minus infinity for negative sums.
            assign avg      = sum_d >>> AVG_LOG2;
            assign avg_x    = avg;

            always_ff @(posedge clock_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    sum_q  <= '0;
                    axis_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        hist_q[i] <= '0;
                    end
                end else if (tick_q) begin
                    hist_q[wptr_q] <= sample;
                    sum_q          <= sum_d;
                    axis_q         <= avg_x;
                end
            end

            assign axis_out_o[gi*32 +: 32] = axis_q;
            assign axis_word[gi]           = axis_q;
        end

        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            logic [DB_W-1:0] cnt_q, cnt_d;
            logic            lvl_d;

            // Any cycle agreeing with the current level restarts the count.
            always_comb begin
                cnt_d = '0;
                lvl_d = btn_level_q[gi];
                if (sync2_q[gi] != btn_level_q[gi]) begin
                    if (cnt_q == DB_LAST) begin
                        lvl_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign btn_level_d[gi] = lvl_d;
        end
    endgenerate

    // A press landing on the same edge as a clearing read survives the clear.
    always_comb begin
        clear_mask = (rd_bus.rd_en && rd_bus.rd_addr == 4'd9) ? flags_q : '0;
        flags_d    = (flags_q & ~clear_mask) | (btn_level_d & ~btn_level_q);
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_bus.rd_en) begin
            rd_data_d = '0;
            case (rd_bus.rd_addr)
                4'd8:    rd_data_d = 32'(btn_level_q);
                4'd9:    rd_data_d = 32'(flags_q);
                4'd10:   rd_data_d = {16'd0, 8'(NUM_BUTTONS), 8'(NUM_AXES)};
                default: begin
                    for (int k = 0; k < NUM_AXES; k++) begin
                        if (rd_bus.rd_addr == 4'(k)) begin
                            rd_data_d = axis_word[k];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            wptr_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            btn_level_q <= '0;
            flags_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            wptr_q      <= wptr_d;
            sync1_q     <= btn_raw_i;
            sync2_q     <= sync1_q;
            btn_level_q <= btn_level_d;
            flags_q     <= flags_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign btn_level_o    = btn_level_q;
    assign sample_tick_o  = tick_q;
    assign rd_bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_sensor_input_hub.sv
// Directed bench for sensor_input_hub: reset, averaging ramp, floor on negatives,
// debounce, read-to-clear race and reset mid-ramp.
module tb_sensor_input_hub;
    logic        clk;
    logic        rst_n;
    logic [17:0] axis_raw;
    logic [3:0]  btn_raw;
    logic [63:0] axis_out;
    logic [3:0]  btn_level;
    logic        tick;
    int          n_cmp;
    int          n_err;

    sensor_input_hub_if bus ();

    sensor_input_hub #(
        .NUM_AXES(2), .RAW_WIDTH(9), .AVG_LOG2(2), .SAMPLE_DIV(4),
        .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock_i       (clk),
        .reset_ni      (rst_n),
        .axis_raw_i    (axis_raw),
        .btn_raw_i     (btn_raw),
        .axis_out_o    (axis_out),
        .btn_level_o   (btn_level),
        .sample_tick_o (tick),
        .rd_bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_axis(input int ch0, input int ch1);
        axis_raw = {9'(ch1), 9'(ch0)};
    endtask

    task automatic wait_tick(output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
            if (tick) found = 1'b1;
        end
        chk("tick_seen", 32'(found), 32'd1);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(posedge clk);
        #1;
        bus.rd_en   = 1'b0;
        d = bus.rd_data;
        $display("read addr %0d -> %h", a, d);
    endtask

    initial begin
        int          w;
        logic [31:0] d;
        int          ch1_seq [4];
        int          exp1 [4];
        n_cmp = 0;
        n_err = 0;
        ch1_seq = '{-3, -3, -3, -2};
        exp1    = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFD};

        rst_n = 1'b0;
        btn_raw = 4'b1111;
        set_axis(5, 7);
        bus.rd_en = 1'b0;
        bus.rd_addr = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_axis0", axis_out[31:0], 32'd0);
        chk("rst_axis1", axis_out[63:32], 32'd0);
        chk("rst_btn", 32'(btn_level), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_rdata", bus.rd_data, 32'd0);

        // First ramp, interrupted by reset between ticks 2 and 3.
        btn_raw = 4'b0000;
        set_axis(40, -3);
        rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_tick(w);
            @(posedge clk);
            #1;
            chk("ramp_a_ch0", axis_out[31:0], 32'(10 * (n + 1)));
            $display("pre-reset tick %0d ch0=%0d", n + 1, $signed(axis_out[31:0]));
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ch0", axis_out[31:0], 32'd0);
        chk("midrst_ch1", axis_out[63:32], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full ramp after release; ch1 checks floor on negative sums.
        for (int n = 0; n < 5; n++) begin
            set_axis(40, ch1_seq[(n < 4) ? n : 3]);
            wait_tick(w);
            if (n == 1 || n == 2) chk("tick_spacing", 32'(w), 32'd3);
            @(posedge clk);
            #1;
            chk("ramp_ch0", axis_out[31:0], 32'((n < 4) ? 10 * (n + 1) : 40));
            if (n < 4) chk("ramp_ch1", axis_out[63:32], exp1[n]);
            $display("tick %0d ch0=%0d ch1=%0d", n + 1, $signed(axis_out[31:0]),
                     $signed(axis_out[63:32]));
        end

        do_read(4'd10, d);
        chk("rd_id", d, 32'h0000_0402);
        do_read(4'd3, d);
        chk("rd_unused", d, 32'd0);
        do_read(4'd0, d);
        chk("rd_ch0", d, 32'd40);
        bus.rd_addr = 4'd8;
        @(posedge clk);
        #1;
        chk("rd_hold", d, bus.rd_data);
        chk("rd_hold_val", bus.rd_data, 32'd40);

        // 5-clock glitch must not pass the debouncer.
        btn_raw = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        btn_raw = 4'b0000;
        repeat (15) @(posedge clk);
        #1;
        chk("glitch_lvl", 32'(btn_level), 32'd0);
        do_read(4'd9, d);
        chk("glitch_flags", d, 32'd0);

        // Held press: level rises exactly 10 clocks after the input edge.
        btn_raw = 4'b0001;
        repeat (9) @(posedge clk);
        #1;
        chk("press_lvl_9", 32'(btn_level), 32'd0);
        @(posedge clk);
        #1;
        chk("press_lvl_10", 32'(btn_level), 32'd1);
        $display("button 0 level=%b", btn_level);

        // Read of flags on the same edge that button 2's level rises.
        btn_raw = 4'b0101;
        repeat (9) @(posedge clk);
        #1;
        do_read(4'd9, d);
        chk("race_rd", d, 32'h1);
        chk("race_lvl", 32'(btn_level), 32'h5);
        do_read(4'd9, d);
        chk("race_rd2", d, 32'h4);
        do_read(4'd9, d);
        chk("race_rd3", d, 32'h0);
        do_read(4'd8, d);
        chk("rd_lvl", d, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
